vend_dispense_arbiter: RTL and testbench

- Shares one physical dispense motor and one change ejector between two coin-accepting vending channels, ch0 and ch1.
- Each channel's coin FSM raises a vend request, with a change-owed flag, once 15 cents has been reached.
- This block grants the shared mechanism round-robin, sequences the motor and ejector timing, and acknowledges completion.
- It also locks out further coin entry on each channel while that channel's vend is pending or in service.

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_timer.sv | 27 ++
 rtl/vend_dispense_arbiter.sv | 148 ++++++++++++++
 tb/tb_vend_dispense_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the two-channel vend dispense arbiter.
package vend_pkg;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned TIMER_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPENSE = 3'd1,
    CHANGE   = 3'd2,
    DONE     = 3'd3,
    FAULT    = 3'd4
  } state_t;

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; done_c flags a zero count (last cycle of an interval).
module vend_timer
  import vend_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               count_en,
  output logic               done_c
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_en && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one dispense motor and change ejector between two
// vend channels, with motor/ejector sequencing, jam fault and coin lockout.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int unsigned DISPENSE_CYCLES = 4,
  parameter int unsigned CHANGE_CYCLES   = 3
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] chg,
  input  logic              jam,
  output logic [NUM_CH-1:0] ack,
  output logic              grant_id,
  output logic              busy,
  output logic              motor_on,
  output logic              eject_on,
  output logic [NUM_CH-1:0] coin_lockout,
  output logic              fault
);

  localparam logic [TIMER_W-1:0] DISP_LOAD = TIMER_W'(DISPENSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CHG_LOAD  = TIMER_W'(CHANGE_CYCLES - 1);

  state_t              state_q, state_n;
  logic                ptr_q, ptr_n;
  logic                chg_q, chg_n;
  logic [NUM_CH-1:0]   ack_n, lock_n;
  logic                gid_n, busy_n, motor_n, eject_n, fault_n;
  logic                t_load, t_en, t_done;
  logic [TIMER_W-1:0]  t_val;

  vend_timer u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (t_load),
    .load_val (t_val),
    .count_en (t_en),
    .done_c   (t_done)
  );

  // State and registered outputs
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      chg_q        <= 1'b0;
      ack          <= '0;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      motor_on     <= 1'b0;
      eject_on     <= 1'b0;
      coin_lockout <= '0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_n;
      ptr_q        <= ptr_n;
      chg_q        <= chg_n;
      ack          <= ack_n;
      grant_id     <= gid_n;
      busy         <= busy_n;
      motor_on     <= motor_n;
      eject_on     <= eject_n;
      coin_lockout <= lock_n;
      fault        <= fault_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    chg_n   = chg_q;
    ack_n   = '0;
    gid_n   = grant_id;
    busy_n  = busy;
    motor_n = 1'b0;
    eject_n = 1'b0;
    fault_n = fault;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (|req) begin
          gid_n   = (req == 2'b11) ? ptr_q : req[1];
          chg_n   = chg[gid_n];
          state_n = DISPENSE;
          motor_n = 1'b1;
          busy_n  = 1'b1;
          t_load  = 1'b1;
          t_val   = DISP_LOAD;
        end
      end
      DISPENSE: begin
        if (jam) begin
          state_n = FAULT;
          fault_n = 1'b1;
          busy_n  = 1'b1;
        end else if (t_done) begin
          if (chg_q) begin
            state_n = CHANGE;
            eject_n = 1'b1;
            t_load  = 1'b1;
            t_val   = CHG_LOAD;
          end else begin
            state_n         = DONE;
            ack_n[grant_id] = 1'b1;
          end
        end else begin
          motor_n = 1'b1;
          t_en    = 1'b1;
        end
      end
      CHANGE: begin
        if (t_done) begin
          state_n         = DONE;
          ack_n[grant_id] = 1'b1;
        end else begin
          eject_n = 1'b1;
          t_en    = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ptr_n   = ~grant_id;
      end
      FAULT: begin
        busy_n  = 1'b1;
        fault_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Lockout follows the pending request or the channel in service
    lock_n = req | {busy & grant_id, busy & ~grant_id};
    if (state_n == FAULT) begin
      lock_n = 2'b11;
    end
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter with D=4, C=3.
module tb_vend_dispense_arbiter;

  logic       clock;
  logic       clear;
  logic [1:0] req;
  logic [1:0] chg;
  logic       jam;
  logic [1:0] ack;
  logic       grant_id;
  logic       busy;
  logic       motor_on;
  logic       eject_on;
  logic [1:0] coin_lockout;
  logic       fault;

  int checks = 0;
  int errors = 0;

  vend_dispense_arbiter #(.DISPENSE_CYCLES(4), .CHANGE_CYCLES(3)) dut (
    .clock        (clock),
    .clear        (clear),
    .req          (req),
    .chg          (chg),
    .jam          (jam),
    .ack          (ack),
    .grant_id     (grant_id),
    .busy         (busy),
    .motor_on     (motor_on),
    .eject_on     (eject_on),
    .coin_lockout (coin_lockout),
    .fault        (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and settle just after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at cycle 0 with the DUT idle
  task automatic do_reset();
    clear = 1'b0;
    req   = 2'b00;
    chg   = 2'b00;
    jam   = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    clear = 1'b0;
    req   = 2'b11;
    chg   = 2'b11;
    jam   = 1'b1;
    repeat (3) step();
    got = {motor_on, eject_on, ack, busy, fault, grant_id, 1'b0};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", got, 8'h00);
    end
    checks++;
    if (coin_lockout !== 2'b00) begin
      errors++;
      $display("FAIL reset_lockout got %b exp 00", coin_lockout);
    end
  endtask

  // ch0 with change owed, then the pointer favours ch1 on a tie
  task automatic test_change_then_pointer();
    logic [5:0] got, exp;
    do_reset();
    req = 2'b01;
    chg = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {(k >= 1 && k <= 4), (k >= 5 && k <= 7), (k == 8) ? 2'b01 : 2'b00, (k <= 8), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL change_path cycle %0d got %b exp %b", k, got, exp);
      end
      checks++;
      if (coin_lockout !== ((k <= 9) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL change_lockout cycle %0d got %b", k, coin_lockout);
      end
      if (k <= 8) begin
        checks++;
        if (grant_id !== 1'b0) begin
          errors++;
          $display("FAIL change_grant cycle %0d got %b exp 0", k, grant_id);
        end
      end
      if (k == 8) req = 2'b00;
    end
    req = 2'b11;
    chg = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {((k >= 1 && k <= 4) || (k >= 7 && k <= 10)), 1'b0,
             (k == 5) ? 2'b10 : ((k == 11) ? 2'b01 : 2'b00),
             ((k <= 5) || (k >= 7 && k <= 11)), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pointer_path cycle %0d got %b exp %b", k, got, exp);
      end
      checks++;
      if (grant_id !== ((k <= 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL pointer_grant cycle %0d got %b", k, grant_id);
      end
      if (k == 5) req = 2'b01;
      if (k == 11) req = 2'b00;
    end
  endtask

  task automatic test_no_change();
    logic [5:0] got, exp;
    do_reset();
    req = 2'b10;
    chg = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {(k >= 1 && k <= 4), 1'b0, (k == 5) ? 2'b10 : 2'b00, (k <= 5), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL nochg_path cycle %0d got %b exp %b", k, got, exp);
      end
      checks++;
      if (grant_id !== 1'b1) begin
        errors++;
        $display("FAIL nochg_grant cycle %0d got %b exp 1", k, grant_id);
      end
      if (k == 5) req = 2'b00;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, exp;
    do_reset();
    req = 2'b11;
    chg = 2'b00;
    for (int k = 1; k <= 13; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {((k >= 1 && k <= 4) || (k >= 7 && k <= 10)), 1'b0,
             (k == 5) ? 2'b01 : ((k == 11) ? 2'b10 : 2'b00),
             ((k <= 5) || (k >= 7 && k <= 11)), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_path cycle %0d got %b exp %b", k, got, exp);
      end
      checks++;
      if (coin_lockout[1] !== (k <= 12)) begin
        errors++;
        $display("FAIL b2b_lockout1 cycle %0d got %b exp %b", k, coin_lockout[1], (k <= 12));
      end
      if (k == 1 || k == 7) begin
        checks++;
        if (grant_id !== (k == 7)) begin
          errors++;
          $display("FAIL b2b_grant cycle %0d got %b exp %b", k, grant_id, (k == 7));
        end
      end
      if (k == 5) req = 2'b10;
      if (k == 11) req = 2'b00;
    end
  endtask

  task automatic test_jam();
    logic [5:0] got;
    do_reset();
    req = 2'b01;
    chg = 2'b01;
    step();
    step();
    checks++;
    if (motor_on !== 1'b1) begin
      errors++;
      $display("FAIL jam_premotor got %b exp 1", motor_on);
    end
    jam = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      step();
      jam = 1'b0;
      req = 2'b00;
      got = {motor_on, eject_on, ack, busy, fault};
      checks++;
      if (got !== 6'b000011) begin
        errors++;
        $display("FAIL jam_fault cycle %0d got %b exp 000011", k, got);
      end
      checks++;
      if (coin_lockout !== 2'b11) begin
        errors++;
        $display("FAIL jam_lockout cycle %0d got %b exp 11", k, coin_lockout);
      end
    end
    clear = 1'b0;
    #1;
    got = {motor_on, eject_on, ack, busy, fault};
    checks++;
    if ({got, coin_lockout, grant_id} !== 9'b0) begin
      errors++;
      $display("FAIL jam_clear got %b exp 000000000", {got, coin_lockout, grant_id});
    end
  endtask

  task automatic test_reset_abort();
    logic [5:0] got, exp;
    do_reset();
    req = 2'b01;
    chg = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {(k >= 1 && k <= 4), (k >= 5), 2'b00, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_pre cycle %0d got %b exp %b", k, got, exp);
      end
    end
    clear = 1'b0;
    #1;
    got = {motor_on, eject_on, ack, busy, fault};
    checks++;
    if (got !== 6'b0) begin
      errors++;
      $display("FAIL abort_drop got %b exp 000000", got);
    end
    clear = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {(k >= 1 && k <= 4), (k >= 5 && k <= 7), (k == 8) ? 2'b01 : 2'b00, (k <= 8), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_rerun cycle %0d got %b exp %b", k, got, exp);
      end
      if (k == 8) req = 2'b00;
    end
  endtask

  task automatic test_latched_inputs();
    logic [5:0] got, exp;
    do_reset();
    req = 2'b01;
    chg = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      step();
      got = {motor_on, eject_on, ack, busy, fault};
      exp = {(k >= 1 && k <= 4), (k >= 5 && k <= 7), (k == 8) ? 2'b01 : 2'b00, (k <= 8), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL latched_path cycle %0d got %b exp %b", k, got, exp);
      end
      if (k == 1) chg = 2'b00;
      if (k == 2) req = 2'b00;
    end
  endtask

  initial begin
    clear = 1'b0;
    req   = 2'b00;
    chg   = 2'b00;
    jam   = 1'b0;
    test_reset();
    test_change_then_pointer();
    test_no_change();
    test_back_to_back();
    test_jam();
    test_reset_abort();
    test_latched_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
